// File: rtl/mioc_dram_pkg.sv
// Shared definitions for the MIOC DRAM address sequencer.
// FSM encodings, default widths and the bus-address row/column split.
package mioc_dram_pkg;

    localparam int AW_DEF          = 16;
    localparam int RAW_DEF         = 8;
    localparam int REF_BITS_DEF    = 7;
    localparam int REF_TIMEOUT_DEF = 512;

    localparam int ROW_LSB = 0;
    localparam int ROW_MSB = 7;
    localparam int COL_LSB = 8;
    localparam int COL_MSB = 15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ROW     = 3'd1,
        S_COL     = 3'd2,
        S_CAS     = 3'd3,
        S_REFRESH = 3'd4,
        S_PRE     = 3'd5
    } state_e;

endpackage

// File: rtl/mioc_dram_refcnt.sv
// Refresh row counter with wrap pulse.
// Optional refresh watchdog when MIOC_DRAM_REFWDOG_EN is defined.
module mioc_dram_refcnt
    import mioc_dram_pkg::*;
#(
    parameter int REF_BITS    = REF_BITS_DEF,
    parameter int REF_TIMEOUT = REF_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                entry,
    output logic [REF_BITS-1:0] ref_row,
    output logic                ref_wrap,
    output logic                ref_late
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_row  <= '0;
            ref_wrap <= 1'b0;
        end else begin
            ref_wrap <= inc && (&ref_row);
            if (inc) begin
                ref_row <= ref_row + REF_BITS'(1);
            end
        end
    end

`ifdef MIOC_DRAM_REFWDOG_EN
    localparam int WW = $clog2(REF_TIMEOUT + 1);
    localparam logic [WW-1:0] WMAX = WW'(REF_TIMEOUT);

    logic [WW-1:0] wdog_q;

    // Saturating: stays at WMAX until the next refresh entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (entry) begin
            wdog_q <= '0;
        end else if (wdog_q != WMAX) begin
            wdog_q <= wdog_q + WW'(1);
        end
    end

    assign ref_late = (wdog_q == WMAX);
`else
    localparam int unused_timeout = REF_TIMEOUT;
    logic unused_entry;
    assign unused_entry = entry;
    assign ref_late     = 1'b0;
`endif

endmodule

// File: rtl/mioc_dram_addr_seq.sv
// MIOC DRAM address sequencer: RAS/CAS tracking, RA mux, protocol checks.
// Build option MIOC_DRAM_REFWDOG_EN enables the refresh watchdog (REF_LATE).
module mioc_dram_addr_seq
    import mioc_dram_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int RAW         = RAW_DEF,
    parameter int REF_BITS    = REF_BITS_DEF,
    parameter int REF_TIMEOUT = REF_TIMEOUT_DEF
) (
    input  logic                B_PHI,
    input  logic                RST_N,
    input  logic [AW-1:0]       BA,
    input  logic                BRFSH_N,
    input  logic                MUX,
    input  logic                RAS_N,
    input  logic                CAS1_N,
    input  logic                CAS2_N,
    input  logic                ERR_CLR,
    output logic [RAW-1:0]      RA,
    output logic                BANK,
    output logic                CYC_ACTIVE,
    output logic [REF_BITS-1:0] REF_ROW,
    output logic                REF_WRAP,
    output logic                PROTO_ERR,
    output logic                REF_LATE
);

    state_e     state_q, state_d;
    logic       ras_q;
    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic       bank_d;
    logic       ref_inc, ref_entry;
    logic       viol;
    logic [RAW-1:0] ra_d;

    logic ras_fall, cas1, cas2, in_col;
    assign ras_fall = ras_q & ~RAS_N;
    assign cas1     = ~CAS1_N;
    assign cas2     = ~CAS2_N;
    assign in_col   = (state_q == S_COL) || (state_q == S_CAS);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        bank_d    = BANK;
        ref_inc   = 1'b0;
        ref_entry = 1'b0;
        unique case (state_q)
            // A RAS fall in PRE is flagged but still starts the new cycle.
            S_IDLE, S_PRE: begin
                if (state_q == S_PRE) state_d = S_IDLE;
                if (ras_fall) begin
                    if (!BRFSH_N) begin
                        state_d   = S_REFRESH;
                        row_d     = 8'({1'b0, REF_ROW});
                        ref_entry = 1'b1;
                    end else begin
                        state_d = S_ROW;
                        row_d   = BA[ROW_MSB:ROW_LSB];
                    end
                end
            end
            S_ROW: begin
                if (MUX) begin
                    state_d = S_COL;
                    col_d   = BA[COL_MSB:COL_LSB];
                end else if (RAS_N) begin
                    state_d = S_PRE;
                end
            end
            S_COL: begin
                if (cas1 || cas2) begin
                    state_d = S_CAS;
                    bank_d  = cas2;
                end else if (RAS_N) begin
                    state_d = S_PRE;
                end
            end
            S_CAS: begin
                if (RAS_N) state_d = S_PRE;
            end
            S_REFRESH: begin
                if (RAS_N) begin
                    state_d = S_PRE;
                    ref_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ra_d = RAW'(BA[ROW_MSB:ROW_LSB]);
        unique case (state_q)
            S_ROW:        ra_d = RAW'(row_q);
            S_COL, S_CAS: ra_d = RAW'(col_q);
            S_REFRESH:    ra_d = RAW'({1'b0, REF_ROW});
            default:      ra_d = RAW'(BA[ROW_MSB:ROW_LSB]);
        endcase
    end

    assign viol = ((cas1 || cas2) && !in_col)
                | (cas1 && cas2)
                | ((state_q == S_PRE) && !RAS_N)
                | (in_col && !MUX);

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            ras_q     <= 1'b1;
            row_q     <= '0;
            col_q     <= '0;
            RA        <= '0;
            BANK      <= 1'b0;
            PROTO_ERR <= 1'b0;
        end else begin
            state_q <= state_d;
            ras_q   <= RAS_N;
            row_q   <= row_d;
            col_q   <= col_d;
            RA      <= ra_d;
            BANK    <= bank_d;
            if (viol) begin
                PROTO_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                PROTO_ERR <= 1'b0;
            end
        end
    end

    assign CYC_ACTIVE = (state_q == S_ROW) || (state_q == S_COL)
                     || (state_q == S_CAS) || (state_q == S_REFRESH);

    mioc_dram_refcnt #(
        .REF_BITS    (REF_BITS),
        .REF_TIMEOUT (REF_TIMEOUT)
    ) u_refcnt (
        .clk      (B_PHI),
        .rst_n    (RST_N),
        .inc      (ref_inc),
        .entry    (ref_entry),
        .ref_row  (REF_ROW),
        .ref_wrap (REF_WRAP),
        .ref_late (REF_LATE)
    );

endmodule

// File: tb/tb_mioc_dram_addr_seq.sv
// Scoreboard bench for mioc_dram_addr_seq.
// Define MIOC_DRAM_REFWDOG_EN to also exercise the refresh watchdog.
module tb_mioc_dram_addr_seq;
    import mioc_dram_pkg::*;

    logic        B_PHI;
    logic        RST_N;
    logic [15:0] BA;
    logic        BRFSH_N, MUX, RAS_N, CAS1_N, CAS2_N, ERR_CLR;
    logic [7:0]  RA;
    logic        BANK, CYC_ACTIVE, REF_WRAP, PROTO_ERR, REF_LATE;
    logic [6:0]  REF_ROW;

    mioc_dram_addr_seq dut (
        .B_PHI      (B_PHI),
        .RST_N      (RST_N),
        .BA         (BA),
        .BRFSH_N    (BRFSH_N),
        .MUX        (MUX),
        .RAS_N      (RAS_N),
        .CAS1_N     (CAS1_N),
        .CAS2_N     (CAS2_N),
        .ERR_CLR    (ERR_CLR),
        .RA         (RA),
        .BANK       (BANK),
        .CYC_ACTIVE (CYC_ACTIVE),
        .REF_ROW    (REF_ROW),
        .REF_WRAP   (REF_WRAP),
        .PROTO_ERR  (PROTO_ERR),
        .REF_LATE   (REF_LATE)
    );

    initial B_PHI = 1'b0;
    always #5 B_PHI = ~B_PHI;

    typedef enum int {F_RA, F_BANK, F_CYC, F_ROW, F_WRAP, F_ERR, F_LATE} fld_e;
    typedef struct {
        string       tag;
        fld_e        fld;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   ref_model = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] obs(fld_e f);
        case (f)
            F_RA:    return 32'(RA);
            F_BANK:  return 32'(BANK);
            F_CYC:   return 32'(CYC_ACTIVE);
            F_ROW:   return 32'(REF_ROW);
            F_WRAP:  return 32'(REF_WRAP);
            F_ERR:   return 32'(PROTO_ERR);
            default: return 32'(REF_LATE);
        endcase
    endfunction

    task automatic exp_v(string tag, fld_e f, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.fld), e.val);
        end
    endtask

    task automatic tick();
        @(posedge B_PHI);
        #1;
        drain();
    endtask

    task automatic read_cycle(input logic [15:0] ba, input logic use_cas2);
        BA = ba; RAS_N = 1'b0;
        exp_v("rd_row_ra", F_RA, 32'(ba[7:0]));
        exp_v("rd_cyc", F_CYC, 1);
        tick();
        BA = ~ba;
        exp_v("rd_row_hold", F_RA, 32'(ba[7:0]));
        tick();
        BA = ba; MUX = 1'b1;
        exp_v("rd_row_mux", F_RA, 32'(ba[7:0]));
        tick();
        CAS1_N = use_cas2; CAS2_N = ~use_cas2;
        exp_v("rd_col_ra", F_RA, 32'(ba[15:8]));
        tick();
        exp_v("rd_bank", F_BANK, 32'(use_cas2));
        exp_v("rd_err", F_ERR, 0);
        RAS_N = 1'b1; CAS1_N = 1'b1; CAS2_N = 1'b1;
        exp_v("rd_cas_ra", F_RA, 32'(ba[15:8]));
        exp_v("rd_pre_cyc", F_CYC, 0);
        tick();
        MUX = 1'b0;
        exp_v("rd_idle_ra", F_RA, 32'(ba[7:0]));
        exp_v("rd_bank_hold", F_BANK, 32'(use_cas2));
        exp_v("rd_err_end", F_ERR, 0);
        tick();
    endtask

    task automatic do_refresh();
        BRFSH_N = 1'b0; RAS_N = 1'b0; BA = 16'hFFFF;
        exp_v("ref_cyc", F_CYC, 1);
        exp_v("ref_row_hold", F_ROW, 32'(ref_model));
`ifdef MIOC_DRAM_REFWDOG_EN
        exp_v("wdog_clr", F_LATE, 0);
`endif
        tick();
        exp_v("ref_ra", F_RA, 32'(ref_model));
        tick();
        RAS_N = 1'b1;
        exp_v("ref_wrap", F_WRAP, 32'(ref_model == 127));
        ref_model = (ref_model + 1) % 128;
        exp_v("ref_inc", F_ROW, 32'(ref_model));
        exp_v("ref_cyc_off", F_CYC, 0);
        tick();
        BRFSH_N = 1'b1;
        exp_v("ref_wrap_end", F_WRAP, 0);
        tick();
    endtask

    task automatic clear_err();
        ERR_CLR = 1'b1;
        exp_v("err_clr", F_ERR, 0);
        tick();
        ERR_CLR = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 1'b0; BA = 16'h0; BRFSH_N = 1'b1; MUX = 1'b0;
        RAS_N = 1'b1; CAS1_N = 1'b1; CAS2_N = 1'b1; ERR_CLR = 1'b0;
        #12;
        exp_v("rst_ra", F_RA, 0);
        exp_v("rst_bank", F_BANK, 0);
        exp_v("rst_cyc", F_CYC, 0);
        exp_v("rst_row", F_ROW, 0);
        exp_v("rst_wrap", F_WRAP, 0);
        exp_v("rst_err", F_ERR, 0);
        exp_v("rst_late", F_LATE, 0);
        drain();
        RST_N = 1'b1;
        tick();

        read_cycle(16'hA55C, 1'b0);
        read_cycle(16'h3C96, 1'b1);

        // CAS while still in the row phase
        RAS_N = 1'b0; BA = 16'h1234;
        tick();
        CAS1_N = 1'b0;
        exp_v("v_cas_row", F_ERR, 1);
        tick();
        CAS1_N = 1'b1; RAS_N = 1'b1;
        exp_v("v_sticky", F_ERR, 1);
        tick();
        tick();
        clear_err();

        // both CAS low; then clear and violation together
        CAS1_N = 1'b0; CAS2_N = 1'b0;
        exp_v("v_dual_cas", F_ERR, 1);
        tick();
        CAS2_N = 1'b1; ERR_CLR = 1'b1;
        exp_v("v_set_wins", F_ERR, 1);
        tick();
        CAS1_N = 1'b1;
        exp_v("v_clr_after", F_ERR, 0);
        tick();
        ERR_CLR = 1'b0;

        // RAS low during precharge restarts the cycle
        RAS_N = 1'b0;
        tick();
        RAS_N = 1'b1;
        tick();
        RAS_N = 1'b0;
        exp_v("v_pre_ras", F_ERR, 1);
        exp_v("v_pre_restart", F_CYC, 1);
        tick();
        RAS_N = 1'b1;
        tick();
        tick();
        clear_err();

        // MUX dropped in column phase
        RAS_N = 1'b0;
        tick();
        MUX = 1'b1;
        tick();
        MUX = 1'b0;
        exp_v("v_mux_col", F_ERR, 1);
        tick();
        RAS_N = 1'b1;
        tick();
        tick();
        clear_err();

        for (int i = 0; i < 128; i++) do_refresh();
        exp_v("ref_full_wrap", F_ROW, 0);
        drain();
        for (int i = 0; i < 5; i++) do_refresh();

        // reset in the middle of a refresh with an error pending
        BRFSH_N = 1'b0; RAS_N = 1'b0;
        tick();
        CAS1_N = 1'b0;
        exp_v("mid_ra", F_RA, 5);
        exp_v("mid_err", F_ERR, 1);
        tick();
        RST_N = 1'b0;
        #2;
        exp_v("mr_ra", F_RA, 0);
        exp_v("mr_bank", F_BANK, 0);
        exp_v("mr_cyc", F_CYC, 0);
        exp_v("mr_row", F_ROW, 0);
        exp_v("mr_wrap", F_WRAP, 0);
        exp_v("mr_err", F_ERR, 0);
        exp_v("mr_late", F_LATE, 0);
        drain();
        CAS1_N = 1'b1; RAS_N = 1'b1; BRFSH_N = 1'b1;
        tick();
        RST_N = 1'b1;
        ref_model = 0;
        exp_v("mr_no_inc", F_ROW, 0);
        exp_v("mr_idle", F_CYC, 0);
        tick();

`ifdef MIOC_DRAM_REFWDOG_EN
        for (int i = 0; i < 520; i++) tick();
        exp_v("wdog_late", F_LATE, 1);
        drain();
        do_refresh();
        exp_v("wdog_cleared", F_LATE, 0);
        drain();
`else
        for (int i = 0; i < 20; i++) tick();
        exp_v("late_tied", F_LATE, 0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
